// File: rtl/pe_seq_ctrl.sv
// Layer sequencer for pe_engine: walks channel tile, row, col and issues one pixel
// per accepted cycle, framed by a buffer prefetch wait and a PE pipeline drain.
module pe_seq_ctrl #(
   parameter int W_SIZE       = 9,
   parameter int W_CHANNEL    = 9,
   parameter int W_FRAME_SIZE = 20,
   parameter int W_DELAY      = 4,
   parameter int PE_DELAY     = 6
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    q_start,
   input  logic [W_SIZE-1:0]       q_width,
   input  logic [W_SIZE-1:0]       q_height,
   input  logic [W_CHANNEL-1:0]    q_channel,
   input  logic                    i_bm_ready,
   output logic                    c_ctrl_data_run,
   output logic [W_SIZE-1:0]       c_row,
   output logic [W_SIZE-1:0]       c_col,
   output logic [W_CHANNEL-1:0]    c_chn,
   output logic [W_FRAME_SIZE-1:0] c_data_count,
   output logic                    c_end_frame,
   output logic                    c_is_first_row,
   output logic                    c_is_last_row,
   output logic                    c_is_first_col,
   output logic                    c_is_last_col,
   output logic                    o_busy,
   output logic                    o_done
);

   localparam int D_MAX  = (W_DELAY > PE_DELAY) ? W_DELAY : PE_DELAY;
   localparam int W_DCNT = $clog2(D_MAX + 1);
   localparam logic [W_DCNT-1:0] PRE_LAST = W_DCNT'(W_DELAY - 1);
   localparam logic [W_DCNT-1:0] DRN_LAST = W_DCNT'(PE_DELAY - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRELOAD,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t                  state;
   logic [W_SIZE-1:0]       w_last;
   logic [W_SIZE-1:0]       h_last;
   logic [W_CHANNEL-1:0]    c_last;
   logic [W_SIZE-1:0]       row;
   logic [W_SIZE-1:0]       col;
   logic [W_CHANNEL-1:0]    chn;
   logic [W_FRAME_SIZE-1:0] idx;
   logic [W_DCNT-1:0]       dcnt;

   logic col_end;
   logic row_end;
   logic chn_end;
   logic last_pix;
   logic zero_cfg;

   assign col_end  = (col == w_last);
   assign row_end  = (row == h_last);
   assign chn_end  = (chn == c_last);
   assign last_pix = col_end && row_end && chn_end;
   assign zero_cfg = (q_width == '0) || (q_height == '0) ||
                     (q_channel == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= IDLE;
         w_last          <= '0;
         h_last          <= '0;
         c_last          <= '0;
         row             <= '0;
         col             <= '0;
         chn             <= '0;
         idx             <= '0;
         dcnt            <= '0;
         c_ctrl_data_run <= 1'b0;
         c_row           <= '0;
         c_col           <= '0;
         c_chn           <= '0;
         c_data_count    <= '0;
         c_end_frame     <= 1'b0;
         c_is_first_row  <= 1'b0;
         c_is_last_row   <= 1'b0;
         c_is_first_col  <= 1'b0;
         c_is_last_col   <= 1'b0;
         o_busy          <= 1'b0;
         o_done          <= 1'b0;
      end else begin
         c_ctrl_data_run <= 1'b0;
         o_done          <= 1'b0;
         unique case (state)
            IDLE: begin
               if (q_start) begin
                  w_last <= q_width - 1'b1;
                  h_last <= q_height - 1'b1;
                  c_last <= q_channel - 1'b1;
                  row    <= '0;
                  col    <= '0;
                  chn    <= '0;
                  idx    <= '0;
                  dcnt   <= '0;
                  o_busy <= 1'b1;
                  if (zero_cfg) begin
                     state  <= DONE;
                     o_done <= 1'b1;
                  end else begin
                     state <= PRELOAD;
                  end
               end
            end
            PRELOAD: begin
               if (dcnt == PRE_LAST) begin
                  dcnt  <= '0;
                  state <= RUN;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            RUN: begin
               if (i_bm_ready) begin
                  c_ctrl_data_run <= 1'b1;
                  c_row           <= row;
                  c_col           <= col;
                  c_chn           <= chn;
                  c_data_count    <= idx;
                  c_end_frame     <= last_pix;
                  c_is_first_row  <= (row == '0);
                  c_is_last_row   <= row_end;
                  c_is_first_col  <= (col == '0);
                  c_is_last_col   <= col_end;
                  idx             <= idx + 1'b1;
                  // col innermost, then row, channel tile outermost
                  if (col_end) begin
                     col <= '0;
                     if (row_end) begin
                        row <= '0;
                        chn <= chn + 1'b1;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
                  if (last_pix) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (dcnt == DRN_LAST) begin
                  state  <= DONE;
                  o_done <= 1'b1;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl: expected pixels queued at start,
// a negedge monitor pops and compares each issued pixel.
module tb_pe_seq_ctrl;

   typedef struct packed {
      logic [8:0]  row;
      logic [8:0]  col;
      logic [8:0]  chn;
      logic [19:0] cnt;
      logic        fr;
      logic        lr;
      logic        fc;
      logic        lc;
      logic        ef;
   } pix_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        q_start = 1'b0;
   logic [8:0]  q_width = '0;
   logic [8:0]  q_height = '0;
   logic [8:0]  q_channel = '0;
   logic        i_bm_ready = 1'b1;
   logic        c_ctrl_data_run;
   logic [8:0]  c_row;
   logic [8:0]  c_col;
   logic [8:0]  c_chn;
   logic [19:0] c_data_count;
   logic        c_end_frame;
   logic        c_is_first_row;
   logic        c_is_last_row;
   logic        c_is_first_col;
   logic        c_is_last_col;
   logic        o_busy;
   logic        o_done;

   pix_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   runs_seen = 0;
   int   first_run_cyc = 0;
   int   last_run_cyc = 0;
   int   done_seen = 0;
   int   done_cyc = 0;

   pe_seq_ctrl dut (
      .clk            (clk),
      .rstn           (rstn),
      .q_start        (q_start),
      .q_width        (q_width),
      .q_height       (q_height),
      .q_channel      (q_channel),
      .i_bm_ready     (i_bm_ready),
      .c_ctrl_data_run(c_ctrl_data_run),
      .c_row          (c_row),
      .c_col          (c_col),
      .c_chn          (c_chn),
      .c_data_count   (c_data_count),
      .c_end_frame    (c_end_frame),
      .c_is_first_row (c_is_first_row),
      .c_is_last_row  (c_is_last_row),
      .c_is_first_col (c_is_first_col),
      .c_is_last_col  (c_is_last_col),
      .o_busy         (o_busy),
      .o_done         (o_done)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc <= cyc + 1;
      end
   end

   task automatic chk(input string name, input longint got,
                      input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // monitor: compare every issued pixel against the queue head
   initial begin
      pix_t e;
      pix_t g;
      forever begin
         @(negedge clk);
         if (rstn && c_ctrl_data_run) begin
            if (runs_seen == 0) first_run_cyc = cyc;
            last_run_cyc = cyc;
            runs_seen++;
            g = '{c_row, c_col, c_chn, c_data_count, c_is_first_row,
                  c_is_last_row, c_is_first_col, c_is_last_col,
                  c_end_frame};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_run: got pixel %h expected none", g);
            end else begin
               e = exp_q.pop_front();
               if (g !== e) begin
                  errors++;
                  $display("FAIL pixel: got %h expected %h", g, e);
               end
            end
         end
         if (rstn && o_done) begin
            done_seen++;
            done_cyc = cyc;
         end
      end
   end

   task automatic push_layer(input int w, input int h, input int c);
      pix_t p;
      int   n = 0;
      for (int ch = 0; ch < c; ch++)
         for (int r = 0; r < h; r++)
            for (int cl = 0; cl < w; cl++) begin
               p.row = 9'(r);
               p.col = 9'(cl);
               p.chn = 9'(ch);
               p.cnt = 20'(n);
               p.fr  = (r == 0);
               p.lr  = (r == h - 1);
               p.fc  = (cl == 0);
               p.lc  = (cl == w - 1);
               p.ef  = (ch == c - 1) && (r == h - 1) && (cl == w - 1);
               exp_q.push_back(p);
               n++;
            end
   endtask

   task automatic start_layer(input int w, input int h, input int c,
                              input bit repulse, output int k0);
      q_width   = 9'(w);
      q_height  = 9'(h);
      q_channel = 9'(c);
      q_start   = 1'b1;
      k0        = cyc;
      @(posedge clk);
      #1;
      if (repulse) begin
         q_width = 9'(w + 1);
         @(posedge clk);
         #1;
      end
      q_start = 1'b0;
   endtask

   task automatic do_layer(input int w, input int h, input int c,
                           input bit gap, input bit repulse);
      int n;
      int d0;
      int k0;
      bit gapped = 1'b0;
      n = w * h * c;
      push_layer(w, h, c);
      runs_seen = 0;
      d0 = done_seen;
      start_layer(w, h, c, repulse, k0);
      if (n > 0) chk("busy_active", 64'(o_busy), 1);
      for (int i = 0; i < 400 && done_seen == d0; i++) begin
         if (gap && !gapped && runs_seen == 2) begin
            gapped = 1'b1;
            i_bm_ready = 1'b0;
            repeat (3) begin
               @(posedge clk);
               #1;
            end
            i_bm_ready = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      chk("busy_after_done", 64'(o_busy), 0);
      repeat (8) @(posedge clk);
      #1;
      chk("done_pulses", done_seen - d0, 1);
      chk("run_count", runs_seen, n);
      if (n > 0) begin
         chk("preload_latency", first_run_cyc - (k0 + 1), 5);
         chk("drain_latency", done_cyc - last_run_cyc, 6);
         chk("run_span", last_run_cyc - first_run_cyc,
             n - 1 + (gap ? 3 : 0));
      end else begin
         chk("zero_done_latency", done_cyc - (k0 + 1), 0);
      end
      chk("scoreboard_empty", exp_q.size(), 0);
      exp_q.delete();
   endtask

   function automatic longint out_vec();
      return longint'({c_ctrl_data_run, c_row, c_col, c_chn, c_data_count,
                       c_end_frame, c_is_first_row, c_is_last_row,
                       c_is_first_col, c_is_last_col, o_busy, o_done});
   endfunction

   initial begin
      int k0;
      int d0;
      #1;
      chk("reset_outputs", out_vec(), 0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_busy", 64'(o_busy), 0);

      do_layer(3, 2, 1, 1'b0, 1'b0);
      do_layer(2, 2, 3, 1'b0, 1'b0);
      do_layer(3, 2, 1, 1'b1, 1'b0);
      do_layer(1, 1, 1, 1'b0, 1'b1);
      do_layer(0, 4, 2, 1'b0, 1'b1);
      do_layer(5, 3, 0, 1'b0, 1'b0);

      push_layer(2, 2, 3);
      runs_seen = 0;
      d0 = done_seen;
      start_layer(2, 2, 3, 1'b0, k0);
      for (int i = 0; i < 100 && runs_seen < 5; i++) begin
         @(posedge clk);
         #1;
      end
      chk("abort_reached", runs_seen, 5);
      #2;
      rstn = 1'b0;
      #1;
      chk("abort_outputs", out_vec(), 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_done", done_seen - d0, 0);
      chk("abort_idle", 64'(o_busy), 0);
      do_layer(2, 2, 3, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
